apb_tx_sequencer: RTL and testbench

- Sequences one serial transmit transaction between the APB register/FIFO side and the clk_tx-domain transmitter front-end.
- On a start command it sends one address phase (the cfg address register, APB addr 3). It then pops exactly cfg_len words (length register, APB addr 4) from the TX data FIFO (APB addr 2) and hands each to the transmitter over a valid/ready handshake.
- Runs entirely on PCLK. The CDC toward clk_tx lives in the transmitter wrapper, not here.

---
 rtl/apb_tx_sequencer.sv | 114 +++++++++++
 tb/tb_apb_tx_sequencer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_tx_sequencer.sv
// Sequences one transmit transaction: an address phase followed by cfg_len FIFO words,
// each offered to the transmitter over a valid/ready handshake. Runs entirely on PCLK.
module apb_tx_sequencer #(
  parameter int DATAWIDTH = 16,
  parameter int ADDRWIDTH = 8,
  parameter int LENWIDTH  = 16,
  parameter int TIMEOUT   = 255
) (
  input  logic                 PCLK,
  input  logic                 PRESETn,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic [ADDRWIDTH-1:0] cfg_addr_i,
  input  logic [LENWIDTH-1:0]  cfg_len_i,
  input  logic                 fifo_empty_i,
  input  logic [DATAWIDTH-1:0] fifo_rdata_i,
  output logic                 fifo_rd_o,
  output logic                 tx_valid_o,
  output logic                 tx_is_addr_o,
  output logic [DATAWIDTH-1:0] tx_data_o,
  input  logic                 tx_ready_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic [LENWIDTH-1:0]  remain_o
);

  localparam int SW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ADDR  = 3'd1;
  localparam logic [2:0] S_FETCH = 3'd2;
  localparam logic [2:0] S_SEND  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_ERR   = 3'd5;

  logic [2:0]           state;
  logic [DATAWIDTH-1:0] data_q;
  logic [LENWIDTH-1:0]  remain;
  logic [SW-1:0]        stall;
  logic                 err_q;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state  <= S_IDLE;
      data_q <= '0;
      remain <= '0;
      stall  <= '0;
      err_q  <= 1'b0;
    end else if (abort_i) begin
      // Abort outranks every other event, including a simultaneous handshake or start.
      if (state != S_IDLE) begin
        state  <= S_IDLE;
        remain <= '0;
        stall  <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (start_i) begin
            err_q <= 1'b0;
            stall <= '0;
            if (cfg_len_i != '0) begin
              data_q <= DATAWIDTH'(cfg_addr_i);
              remain <= cfg_len_i;
              state  <= S_ADDR;
            end else begin
              state <= S_DONE;
            end
          end
        end
        S_ADDR: begin
          if (tx_ready_i) state <= S_FETCH;
        end
        S_FETCH: begin
          if (!fifo_empty_i) begin
            data_q <= fifo_rdata_i;
            stall  <= '0;
            state  <= S_SEND;
          end else begin
            if (stall != SW'(TIMEOUT)) stall <= stall + SW'(1);
            // The cycle whose increment reaches TIMEOUT is the last empty FETCH.
            if (stall >= SW'(TIMEOUT - 1)) state <= S_ERR;
          end
        end
        S_SEND: begin
          if (tx_ready_i) begin
            remain <= remain - LENWIDTH'(1);
            state  <= (remain == LENWIDTH'(1)) ? S_DONE : S_FETCH;
          end
        end
        S_DONE: state <= S_IDLE;
        S_ERR: begin
          err_q <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    tx_valid_o   = (state == S_ADDR) || (state == S_SEND);
    tx_is_addr_o = (state == S_ADDR);
    fifo_rd_o    = (state == S_FETCH) && !fifo_empty_i && !abort_i;
    busy_o       = (state != S_IDLE);
    done_o       = (state == S_DONE);
  end

  assign tx_data_o = data_q;
  assign err_o     = err_q;
  assign remain_o  = remain;

endmodule

// File: tb/tb_apb_tx_sequencer.sv
// Directed bench for apb_tx_sequencer: stimulus pushes expected transmitter words into a
// scoreboard queue; an independent monitor pops and compares on every accepted offer.
module tb_apb_tx_sequencer;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        start_i, abort_i;
  logic [7:0]  cfg_addr_i;
  logic [15:0] cfg_len_i;
  logic        fifo_empty_i;
  logic [15:0] fifo_rdata_i;
  logic        fifo_rd_o, tx_valid_o, tx_is_addr_o, tx_ready_i;
  logic [15:0] tx_data_o;
  logic        busy_o, done_o, err_o;
  logic [15:0] remain_o;

  apb_tx_sequencer #(.DATAWIDTH(16), .ADDRWIDTH(8), .LENWIDTH(16), .TIMEOUT(255)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .start_i(start_i), .abort_i(abort_i),
    .cfg_addr_i(cfg_addr_i), .cfg_len_i(cfg_len_i), .fifo_empty_i(fifo_empty_i),
    .fifo_rdata_i(fifo_rdata_i), .fifo_rd_o(fifo_rd_o), .tx_valid_o(tx_valid_o),
    .tx_is_addr_o(tx_is_addr_o), .tx_data_o(tx_data_o), .tx_ready_i(tx_ready_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .remain_o(remain_o)
  );

  always #5 PCLK = ~PCLK;

  // First-word-fall-through FIFO model
  logic [15:0] fmem [0:255];
  int unsigned wr_ptr = 0;
  int unsigned rd_ptr = 0;
  assign fifo_empty_i = (wr_ptr == rd_ptr);
  assign fifo_rdata_i = fmem[rd_ptr % 256];
  always @(posedge PCLK) if (fifo_rd_o) rd_ptr <= rd_ptr + 1;

  int checks = 0;
  int errors = 0;
  logic [16:0] exp_q [$];
  int unsigned exp_remain = 0;
  int done_cnt = 0, pop_cnt = 0, valid_cnt = 0, stall_cnt = 0;

  // Scoreboard monitor
  initial begin : monitor
    logic        pend;
    logic [16:0] pend_word, w;
    pend = 1'b0;
    pend_word = '0;
    forever begin
      @(negedge PCLK);
      if (PRESETn) begin
        if (done_o) done_cnt++;
        if (fifo_rd_o) pop_cnt++;
        if (tx_valid_o) valid_cnt++;
        if (busy_o && !tx_valid_o && fifo_empty_i) stall_cnt++;
        if (pend && tx_valid_o) begin
          checks++;
          if ({tx_is_addr_o, tx_data_o} !== pend_word) begin
            errors++;
            $display("FAIL hold_stable: got %05h expected %05h", {tx_is_addr_o, tx_data_o}, pend_word);
          end
        end
        if (tx_valid_o && tx_ready_i && !abort_i) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL tx_word: got %05h expected none", {tx_is_addr_o, tx_data_o});
          end else begin
            w = exp_q.pop_front();
            if ({tx_is_addr_o, tx_data_o} !== w) begin
              errors++;
              $display("FAIL tx_word: got %05h expected %05h", {tx_is_addr_o, tx_data_o}, w);
            end
          end
          if (!tx_is_addr_o) begin
            checks++;
            if (remain_o !== exp_remain[15:0]) begin
              errors++;
              $display("FAIL remain_count: got %0d expected %0d", remain_o, exp_remain);
            end
            exp_remain--;
          end
          pend = 1'b0;
        end else begin
          pend = tx_valid_o && !abort_i;
          pend_word = {tx_is_addr_o, tx_data_o};
        end
      end else begin
        pend = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [15:0] d, input logic expect_sent);
    fmem[wr_ptr % 256] = d;
    wr_ptr++;
    if (expect_sent) exp_q.push_back({1'b0, d});
  endtask

  task automatic do_start(input logic [7:0] addr, input logic [15:0] len);
    start_i = 1'b1;
    cfg_addr_i = addr;
    cfg_len_i = len;
    exp_remain = len;
    @(posedge PCLK); #1;
    start_i = 1'b0;
    cfg_addr_i = 8'hFF;
    cfg_len_i = 16'h0000;
  endtask

  task automatic wait_idle(input int max);
    for (int c = 0; c < max; c++) begin
      if (!busy_o) break;
      @(posedge PCLK); #1;
    end
    chk("idle_reached", busy_o, 0);
  endtask

  task automatic wait_send(input logic [15:0] d, input string name);
    for (int c = 0; c < 100; c++) begin
      if (tx_valid_o && !tx_is_addr_o && tx_data_o == d) break;
      @(posedge PCLK); #1;
    end
    chk(name, {tx_valid_o, tx_data_o}, {1'b1, d});
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

  initial begin : stim
    int d0, p0, v0, s0;
    PRESETn = 1'b0;
    start_i = 1'b0; abort_i = 1'b0; tx_ready_i = 1'b0;
    cfg_addr_i = '0; cfg_len_i = '0;
    repeat (3) @(posedge PCLK);
    #1;
    chk("rst_valid", tx_valid_o, 0);
    chk("rst_busy", busy_o, 0);
    PRESETn = 1'b1;
    @(posedge PCLK); #1;
    chk("rst_outs", {fifo_rd_o, tx_is_addr_o, done_o, err_o}, 0);
    chk("rst_data", tx_data_o, 0);
    chk("rst_remain", remain_o, 0);

    // Basic single word
    tx_ready_i = 1'b1;
    exp_q.push_back({1'b1, 16'h0005});
    push(16'h0001, 1'b1);
    d0 = done_cnt; p0 = pop_cnt;
    do_start(8'h05, 16'd1);
    chk("latency_addr", {tx_valid_o, tx_is_addr_o}, 2'b11);
    wait_idle(50);
    chk("basic_done", done_cnt - d0, 1);
    chk("basic_pops", pop_cnt - p0, 1);
    chk("basic_err", err_o, 0);
    chk("basic_sb_empty", exp_q.size(), 0);

    // 42-word burst with toggling ready
    tx_ready_i = 1'b0;
    exp_q.push_back({1'b1, 16'h0012});
    for (int i = 1; i <= 42; i++) push(16'(i), 1'b1);
    d0 = done_cnt; p0 = pop_cnt;
    do_start(8'h12, 16'd42);
    for (int c = 0; c < 400; c++) begin
      if (!busy_o) break;
      tx_ready_i = ~tx_ready_i;
      @(posedge PCLK); #1;
    end
    chk("burst_idle", busy_o, 0);
    chk("burst_done", done_cnt - d0, 1);
    chk("burst_pops", pop_cnt - p0, 42);
    chk("burst_remain", remain_o, 0);
    chk("burst_sb_empty", exp_q.size(), 0);

    // Zero length
    d0 = done_cnt; p0 = pop_cnt; v0 = valid_cnt;
    do_start(8'h07, 16'd0);
    chk("zero_done_pulse", {done_o, busy_o}, 2'b11);
    @(posedge PCLK); #1;
    chk("zero_done_drop", {done_o, busy_o}, 2'b00);
    chk("zero_pops", pop_cnt - p0, 0);
    chk("zero_valid", valid_cnt - v0, 0);
    chk("zero_done_cnt", done_cnt - d0, 1);

    // Underrun: 3 requested, 2 available
    tx_ready_i = 1'b1;
    exp_q.push_back({1'b1, 16'h0009});
    push(16'h00A1, 1'b1);
    push(16'h00A2, 1'b1);
    d0 = done_cnt; p0 = pop_cnt; s0 = stall_cnt;
    do_start(8'h09, 16'd3);
    wait_idle(400);
    chk("underrun_err", err_o, 1);
    chk("underrun_no_done", done_cnt - d0, 0);
    chk("underrun_pops", pop_cnt - p0, 2);
    chk("underrun_stall_cycles", stall_cnt - s0, 256);
    chk("underrun_sb_empty", exp_q.size(), 0);

    // Abort during SEND of word 4, ready high
    exp_q.push_back({1'b1, 16'h0033});
    for (int i = 1; i <= 10; i++) push(16'h0B00 + 16'(i), i < 4);
    d0 = done_cnt;
    do_start(8'h33, 16'd10);
    chk("restart_clears_err", err_o, 0);
    wait_send(16'h0B04, "abort_reach_word4");
    abort_i = 1'b1;
    @(posedge PCLK); #1;
    chk("abort_idle", {tx_valid_o, busy_o, fifo_rd_o}, 0);
    chk("abort_remain", remain_o, 0);
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_sb_empty", exp_q.size(), 0);
    abort_i = 1'b0;
    wr_ptr = rd_ptr;
    exp_q.push_back({1'b1, 16'h0058});
    push(16'h00C1, 1'b1);
    push(16'h00C2, 1'b1);
    d0 = done_cnt;
    do_start(8'h58, 16'd2);
    wait_idle(50);
    chk("abort_restart_done", done_cnt - d0, 1);
    chk("abort_restart_sb", exp_q.size(), 0);

    // Asynchronous reset during SEND
    exp_q.push_back({1'b1, 16'h0021});
    push(16'h00D1, 1'b1);
    push(16'h00D2, 1'b1);
    push(16'h00D3, 1'b0);
    push(16'h00D4, 1'b0);
    do_start(8'h21, 16'd4);
    wait_send(16'h00D2, "reset_reach_word2");
    tx_ready_i = 1'b0;
    #2;
    PRESETn = 1'b0;
    #1;
    chk("async_rst_outs", {tx_valid_o, busy_o, fifo_rd_o, done_o, tx_is_addr_o}, 0);
    chk("async_rst_data", tx_data_o, 0);
    chk("async_rst_remain", remain_o, 0);
    void'(exp_q.pop_back());
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    wr_ptr = rd_ptr;
    tx_ready_i = 1'b1;
    exp_q.push_back({1'b1, 16'h004A});
    push(16'h00E1, 1'b1);
    push(16'h00E2, 1'b1);
    push(16'h00E3, 1'b1);
    d0 = done_cnt; p0 = pop_cnt;
    do_start(8'h4A, 16'd3);
    wait_idle(50);
    chk("post_rst_done", done_cnt - d0, 1);
    chk("post_rst_pops", pop_cnt - p0, 3);
    chk("post_rst_sb", exp_q.size(), 0);

    repeat (2) @(posedge PCLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
